// File: rtl/axi_rd_bridge.sv
// axi_rd_bridge
//   Converts a cache read request (address + burst length) into a single AXI
//   AR transaction and streams the R beats straight back to the cache with no
//   added latency. At most one read is outstanding at a time.
//
//   Ports
//     clk, rstn                      clock, asynchronous active-low reset
//     r_req/r_addr/r_length/r_rdy    cache request channel (r_rdy = accept)
//     r_data_ready                   cache can take a return beat
//     ret_valid/ret_last/ret_data    return beats to the cache
//     arid..arvalid, arready         AXI read address channel
//     rdata/rresp/rlast/rvalid,rready AXI read data channel
//     rd_err                         sticky error flag (RD_BRIDGE_ERR_EN only)
//
//   Build option: define RD_BRIDGE_ERR_EN to add the rd_err port, which sets
//   on any beat with a non-OKAY rresp or with rlast disagreeing with the
//   latched burst length, and stays set until reset.
module axi_rd_bridge #(
    parameter logic [3:0] ARID_VAL = 4'd0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        r_req,
    input  logic [31:0] r_addr,
    input  logic [7:0]  r_length,
    output logic        r_rdy,
    input  logic        r_data_ready,
    output logic        ret_valid,
    output logic        ret_last,
    output logic [31:0] ret_data,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
`ifdef RD_BRIDGE_ERR_EN
    ,
    output logic        rd_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [7:0]  cnt_q;
    logic        xfer;

    // A beat moves whenever we are in R and both sides agree.
    assign xfer = (state_q == R) && rvalid && r_data_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (r_req)         state_d = AR;
            AR:      if (arready)       state_d = R;
            R:       if (xfer && rlast) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && r_req) begin
                addr_q <= r_addr;
                len_q  <= r_length;
            end
            if (state_q == AR && arready)
                cnt_q <= 8'd0;
            else if (xfer)
                cnt_q <= cnt_q + 8'd1;
        end
    end

    // Request side
    assign r_rdy   = (state_q == IDLE);

    // AR channel: fields come from registers, so they are stable while stalled.
    assign arvalid = (state_q == AR);
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arid    = ARID_VAL;

    // R channel is a pure pass-through; termination follows rlast only.
    assign rready    = (state_q == R) && r_data_ready;
    assign ret_valid = (state_q == R) && rvalid;
    assign ret_last  = xfer && rlast;
    assign ret_data  = rdata;

`ifdef RD_BRIDGE_ERR_EN
    logic rd_err_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            rd_err_q <= 1'b0;
        else if (xfer && ((rresp != 2'b00) || (rlast != (cnt_q == len_q))))
            rd_err_q <= 1'b1;
    end
    assign rd_err = rd_err_q;
`else
    // The beat counter and rresp only feed the error check.
    logic unused_sink;
    assign unused_sink = ^{rresp, cnt_q};
`endif

endmodule

// File: tb/tb_axi_rd_bridge.sv
module tb_axi_rd_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        r_req;
    logic [31:0] r_addr;
    logic [7:0]  r_length;
    logic        r_rdy;
    logic        r_data_ready;
    logic        ret_valid, ret_last;
    logic [31:0] ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
`ifdef RD_BRIDGE_ERR_EN
    logic        rd_err;
`endif

    always #5 clk = ~clk;

    axi_rd_bridge #(.ARID_VAL(4'd5)) dut (
        .clk(clk), .rstn(rstn),
        .r_req(r_req), .r_addr(r_addr), .r_length(r_length), .r_rdy(r_rdy),
        .r_data_ready(r_data_ready),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
`ifdef RD_BRIDGE_ERR_EN
        , .rd_err(rd_err)
`endif
    );

    int checks = 0;
    int passes = 0;
    bit err_exp = 1'b0;

    logic [32:0] exp_r[$];   // {last, data}
    logic [43:0] exp_ar[$];  // {arid, araddr, arlen}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every handshake the DUT presents is matched against the queues.
    logic [32:0] mr;
    logic [43:0] ma;
    always @(negedge clk) begin
        if (rstn) begin
            if (ret_valid && rready) begin
                if (exp_r.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    mr = exp_r.pop_front();
                    chk("ret_data", ret_data, mr[31:0]);
                    chk("ret_last", ret_last, mr[32]);
                end
            end
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) chk("unexpected_ar", 1, 0);
                else begin
                    ma = exp_ar.pop_front();
                    chk("arid", arid, ma[43:40]);
                    chk("araddr", araddr, ma[39:8]);
                    chk("arlen", arlen, ma[7:0]);
                    chk("arsize", arsize, 3'b010);
                    chk("arburst", arburst, 2'b01);
                end
            end
        end
    end

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_ret_last", ret_last, 0);
        chk("rst_r_rdy", r_rdy, 1);
`ifdef RD_BRIDGE_ERR_EN
        chk("rst_rd_err", rd_err, 0);
`endif
        exp_r.delete();
        exp_ar.delete();
        err_exp = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0; r_req = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_r_rdy", r_rdy, 1);
        @(posedge clk); #1;
    endtask

    // Present a request and hold it until accepted; leaves the FSM in AR.
    task automatic start_req(input logic [31:0] a, input logic [7:0] l, input bit hold, output int waits);
        r_req = 1'b1; r_addr = a; r_length = l;
        exp_ar.push_back({4'd5, a, l});
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (r_rdy) break;
            waits++;
            if (waits > 50) begin chk("req_timeout", 0, 1); break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        // While busy a held request with different fields must be ignored.
        if (hold) begin r_addr = 32'hBAD0_0000; r_length = 8'd9; end
        else r_req = 1'b0;
        @(negedge clk);
        chk("arvalid_after_acc", arvalid, 1);
        chk("r_rdy_in_ar", r_rdy, 0);
        @(posedge clk); #1;
    endtask

    task automatic ar_phase(input int delay, input logic [31:0] a);
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            chk("arvalid_hold", arvalid, 1);
            chk("araddr_hold", araddr, a);
            @(posedge clk); #1;
        end
        arready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        arready = 1'b0;
        @(negedge clk);
        chk("arvalid_drop", arvalid, 0);
        @(posedge clk); #1;
    endtask

    // Slave model: beat i carries base+i; rlast on beat rlast_at.
    task automatic r_phase(input logic [31:0] base, input int len, input int rlast_at,
                           input bit bp, input int abort_at, input int err_beat);
        int i = 0;
        int cyc = 0;
        bit x;
        for (int k = 0; k <= rlast_at; k++) exp_r.push_back({(k == rlast_at), base + 32'(k)});
        while (i <= rlast_at) begin
            rvalid = 1'b1;
            rdata  = base + 32'(i);
            rlast  = (i == rlast_at);
            rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            r_data_ready = bp ? ~cyc[0] : 1'b1;
            @(negedge clk);
            chk("rready_mirror", rready, r_data_ready);
            chk("ret_valid_in_r", ret_valid, 1);
            chk("r_rdy_in_r", r_rdy, 0);
            chk("ret_last_gate", ret_last, r_data_ready && rlast);
`ifdef RD_BRIDGE_ERR_EN
            chk("rd_err", rd_err, err_exp);
            if (r_data_ready && ((rresp != 2'b00) || (rlast != (i == len)))) err_exp = 1'b1;
`endif
            x = r_data_ready;
            @(posedge clk); #1;
            cyc++;
            if (x) i++;
            if (i == abort_at) begin do_reset(); return; end
            if (cyc > 400) begin chk("r_timeout", 0, 1); break; end
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    // One cycle in IDLE with rvalid asserted: everything on R must stay gated.
    task automatic idle_check();
        rvalid = 1'b1; r_data_ready = 1'b1;
        @(negedge clk);
        chk("idle_r_rdy", r_rdy, 1);
        chk("idle_arvalid", arvalid, 0);
        chk("idle_ret_valid", ret_valid, 0);
        chk("idle_rready", rready, 0);
        chk("idle_ret_last", ret_last, 0);
        chk("r_queue_empty", exp_r.size(), 0);
`ifdef RD_BRIDGE_ERR_EN
        chk("idle_rd_err", rd_err, err_exp);
`endif
        @(posedge clk); #1;
        rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rstn = 1'b0; r_req = 1'b0; r_addr = '0; r_length = '0; r_data_ready = 1'b0;
        arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b1;
        @(posedge clk); #1;
        chk("reset_r_rdy", r_rdy, 1);
        chk("reset_arvalid", arvalid, 0);
        chk("reset_ret_valid", ret_valid, 0);
        chk("reset_rready", rready, 0);
        chk("reset_araddr", araddr, 0);
        chk("reset_arlen", arlen, 0);
        rvalid = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Line refill, arready two cycles after arvalid
        start_req(32'h1C00_0040, 8'd15, 1'b0, w);
        ar_phase(1, 32'h1C00_0040);
        r_phase(32'h1000_0000, 15, 15, 1'b0, -1, -1);
        idle_check();

        // Single word
        start_req(32'h2000_0004, 8'd0, 1'b0, w);
        ar_phase(0, 32'h2000_0004);
        r_phase(32'hDEAD_BEEF, 0, 0, 1'b0, -1, -1);
        idle_check();

        // Backpressure toggling on r_data_ready
        start_req(32'h1C00_0100, 8'd15, 1'b0, w);
        ar_phase(0, 32'h1C00_0100);
        r_phase(32'hA5A5_0000, 15, 15, 1'b1, -1, -1);
        idle_check();

        // Reset at beat 5, then a normal request
        start_req(32'h1C00_0200, 8'd15, 1'b0, w);
        ar_phase(0, 32'h1C00_0200);
        r_phase(32'h5000_0000, 15, 15, 1'b0, 5, -1);
        start_req(32'h0000_0010, 8'd0, 1'b0, w);
        ar_phase(0, 32'h0000_0010);
        r_phase(32'h1234_5678, 0, 0, 1'b0, -1, -1);
        idle_check();

        // Back-to-back with r_req held high
        start_req(32'h3000_0000, 8'd3, 1'b1, w);
        ar_phase(2, 32'h3000_0000);
        r_phase(32'h7700_0000, 3, 3, 1'b0, -1, -1);
        start_req(32'h3000_0040, 8'd1, 1'b0, w);
        chk("b2b_accept_wait", 64'(w), 0);
        ar_phase(0, 32'h3000_0040);
        r_phase(32'h8800_0000, 1, 1, 1'b0, -1, -1);
        idle_check();

        // Early rlast: burst ends on rlast, not on the length
        start_req(32'h0000_0040, 8'd3, 1'b0, w);
        ar_phase(0, 32'h0000_0040);
        r_phase(32'h9900_0000, 3, 1, 1'b0, -1, -1);
        idle_check();

`ifdef RD_BRIDGE_ERR_EN
        chk("err_after_mismatch", rd_err, 1);
        do_reset();
        start_req(32'h1C00_0300, 8'd15, 1'b0, w);
        ar_phase(0, 32'h1C00_0300);
        r_phase(32'hC0DE_0000, 15, 15, 1'b0, -1, 3);
        idle_check();
        chk("err_sticky", rd_err, 1);
        do_reset();
`endif

        chk("ar_queue_empty", exp_ar.size(), 0);
        chk("r_queue_empty_end", exp_r.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axi_rd_bridge.md
AXI_RD_BRIDGE -- requirements
Module: axi_rd_bridge

Interface
REQ-001 The block SHALL provide parameter ARID_VAL, default 4'd0, the constant driven on arid.
REQ-002 The block SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rstn  input  1  asynchronous active-low reset.
REQ-004 The block SHALL provide port r_req  input  1  cache read request, level, held until accepted.
REQ-005 The block SHALL provide port r_addr  input  32  request start byte address.
REQ-006 The block SHALL provide port r_length  input  8  burst length minus one (15 = line refill, 0 = single word).
REQ-007 The block SHALL provide port r_rdy  output  1  request accept strobe.
REQ-008 The block SHALL provide port r_data_ready  input  1  cache can take a return beat.
REQ-009 The block SHALL provide ports ret_valid  output  1, ret_last  output  1, ret_data  output  32  return beat to the cache.
REQ-010 The block SHALL provide AXI AR ports arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1 (outputs) and arready 1 (input).
REQ-011 The block SHALL provide AXI R ports rdata 32, rresp 2, rlast 1, rvalid 1 (inputs) and rready 1 (output).
REQ-012 The block SHALL provide port rd_err  output  1  sticky error flag, present only when RD_BRIDGE_ERR_EN is defined.

Function
REQ-013 The block SHALL implement states IDLE, AR, R; one read transaction outstanding at most.
REQ-014 In IDLE r_rdy SHALL be 1; in AR and R r_rdy SHALL be 0.
REQ-015 When r_req && r_rdy in cycle N, the block SHALL latch r_addr and r_length and enter AR, with arvalid=1 from cycle N+1.
REQ-016 In AR, araddr/arlen SHALL equal the latched values, arsize=3'b010, arburst=2'b01 (INCR), arid=ARID_VAL; all held stable while arvalid && !arready.
REQ-017 On arvalid && arready the block SHALL deassert arvalid next cycle and enter R.
REQ-018 In R, rready SHALL equal r_data_ready and ret_valid SHALL equal rvalid combinationally; ret_data SHALL equal rdata; zero added latency per beat.
REQ-019 A beat transfers when rvalid && rready; an 8-bit beat counter SHALL reset to 0 on entering R and increment per transfer.
REQ-020 ret_last SHALL be 1 on the transfer beat where rlast=1; that transfer SHALL return the FSM to IDLE the next cycle.
REQ-021 Burst termination SHALL follow rlast only; counter mismatch (rlast early or late vs latched length) SHALL NOT alter the data path.
REQ-022 Outside R, rready, ret_valid, ret_last SHALL be 0; outside AR, arvalid SHALL be 0.
REQ-023 A new r_req arriving in the cycle the FSM returns to IDLE SHALL be accepted that cycle (back-to-back, one idle cycle between bursts).
REQ-024 r_req while not in IDLE SHALL be ignored without effect.

Reset
REQ-025 rstn low SHALL immediately force IDLE, counter 0, latched address/length 0, arvalid=0, rready=0, ret_valid=0, ret_last=0, rd_err=0; r_rdy reads 1 after reset.
REQ-026 Reset mid-burst SHALL abandon the transaction; the system reset also resets the interconnect, so no drain is performed.

Configuration
REQ-027 With RD_BRIDGE_ERR_EN defined, rd_err SHALL set on any transfer with rresp != 2'b00 or with rlast mismatching counter==latched length, and SHALL stay set until reset.
REQ-028 Without RD_BRIDGE_ERR_EN, the rd_err port and its logic SHALL be absent; rresp SHALL be ignored.

Verification
REQ-029 Line refill: r_req, r_addr=0x1C000040, r_length=15, arready after 2 cycles -> arlen=15, araddr=0x1C000040, 16 ret_valid beats, ret_last on 16th, IDLE next cycle.
REQ-030 Single word: r_length=0, rdata=0xDEADBEEF with rlast -> one beat, ret_data=0xDEADBEEF, ret_last=1.
REQ-031 Backpressure: r_data_ready toggles 1/0 during 16-beat burst with rvalid held -> rready mirrors it, no beat lost or duplicated, data order preserved.
REQ-032 Reset at beat 5 of 16 -> all outputs reset values same cycle, r_rdy=1 after release, next request handled normally.
REQ-033 Back-to-back: r_req held high across two requests -> second accepted the cycle FSM re-enters IDLE, r_rdy=0 during AR and R.
REQ-034 With RD_BRIDGE_ERR_EN: rresp=2'b10 on beat 3 -> rd_err=1 from next cycle until reset; data path unchanged.
